// File: rtl/clk_div_prog_if.sv
// Divisor reload bus for clk_div_prog.
// The controller side (master) drives the new divisor and its load strobe.
// The divider side (slave) reports whether a captured divisor is still waiting for a period boundary.
interface clk_div_prog_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] DIV_IN;
  logic             DIV_LOAD;
  logic             DIV_PEND;

  modport master (output DIV_IN, output DIV_LOAD, input DIV_PEND);
  modport slave  (input DIV_IN, input DIV_LOAD, output DIV_PEND);
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / tick generator.
//
// - CLK_OUT is a registered square wave: low for floor(D/2) cycles, then high for ceil(D/2) cycles.
// - TICK is a one-cycle pulse on the first cycle of each period.
// - A new divisor is captured into a shadow register and takes effect only at a period boundary,
//   so the period in progress always completes at its original length.
//
// Optional feature: define CLK_DIV_SYNC_CLR_EN to add the SYNC_CLR input.
// SYNC_CLR restarts the phase synchronously, which lets several dividers be aligned.
module clk_div_prog #(
  parameter int          WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 524288
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          EN,
  clk_div_prog_if.slave div_bus,
`ifdef CLK_DIV_SYNC_CLR_EN
  input  logic          SYNC_CLR,
`endif
  output logic          CLK_OUT,
  output logic          TICK
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] shadow;
  logic             pend;

  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] div_nx;
  logic [WIDTH-1:0] shadow_nx;
  logic             pend_nx;
  logic             tick_nx;
  logic             clk_out_nx;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] apply_val;
  logic             have_new;
  logic             wrap;
  logic             sync_clr;

`ifdef CLK_DIV_SYNC_CLR_EN
  assign sync_clr = SYNC_CLR;
`else
  assign sync_clr = 1'b0;
`endif

  // Divisors below 2 would make the period unreachable or degenerate, so they are clamped to 2.
  assign load_val  = (div_bus.DIV_IN < DIV_MIN) ? DIV_MIN : div_bus.DIV_IN;
  // A load strobe in the same cycle takes precedence over an older pending value.
  assign apply_val = div_bus.DIV_LOAD ? load_val : shadow;
  assign have_new  = div_bus.DIV_LOAD | pend;
  // div_act is never below 2, so the subtraction cannot underflow.
  assign wrap      = (cnt == (div_act - WIDTH'(1)));

  // Next-state computation for counter, active divisor, shadow and outputs.
  always_comb begin
    cnt_nx     = cnt;
    div_nx     = div_act;
    shadow_nx  = shadow;
    pend_nx    = pend;
    tick_nx    = 1'b0;

    if (div_bus.DIV_LOAD) begin
      shadow_nx = load_val;
      pend_nx   = 1'b1;
    end

    if (sync_clr) begin
      cnt_nx  = '0;
      pend_nx = 1'b0;
      if (have_new) div_nx = apply_val;
    end else if (EN) begin
      if (wrap) begin
        cnt_nx  = '0;
        tick_nx = 1'b1;
        pend_nx = 1'b0;
        if (have_new) div_nx = apply_val;
      end else begin
        cnt_nx = cnt + WIDTH'(1);
      end
    end

    // The output is computed from the updated count and divisor, so it stays aligned with cnt.
    // When frozen, cnt and div_act are unchanged, so this reproduces the held value.
    clk_out_nx = (cnt_nx >= (div_nx >> 1));
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt     <= '0;
      div_act <= DIV_RST;
      shadow  <= '0;
      pend    <= 1'b0;
      CLK_OUT <= 1'b0;
      TICK    <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      div_act <= div_nx;
      shadow  <= shadow_nx;
      pend    <= pend_nx;
      CLK_OUT <= clk_out_nx;
      TICK    <= tick_nx;
    end
  end

  assign div_bus.DIV_PEND = pend;

endmodule
